// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: launches the shared multiplier/divisor, waits for completion and drives HI/LO writeback.
// Outputs are registered from the next-state decode, so they behave as Moore outputs of the current state.
module muldiv_sequencer #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req,
  input  logic       i_op_div,
  input  logic       i_abort,
  input  logic       i_mult_fim,
  input  logic       i_div_fim,
  input  logic       i_div_by_zero,
  output logic       o_mult_start,
  output logic       o_div_start,
  output logic       o_hi_sel,
  output logic       o_lo_sel,
  output logic       o_hi_write,
  output logic       o_lo_write,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_exc,
  output logic [1:0] o_exc_code
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_WRITE, S_DONE, S_EXC} state_t;
  state_t            r_state, w_nxt;
  logic              r_op;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_op, w_fim, w_dbz, w_tmo;
  assign w_op  = (r_state == S_IDLE) ? i_op_div : r_op;
  assign w_fim = r_op ? i_div_fim : i_mult_fim;
  assign w_dbz = r_op && i_div_by_zero;
  assign w_tmo = r_cnt == CNT_W'(TIMEOUT - 1);
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  w_nxt = i_req ? S_START : S_IDLE;
      S_START: w_nxt = i_abort ? S_IDLE : S_WAIT;
      S_WAIT:  w_nxt = i_abort ? S_IDLE : w_dbz ? S_EXC : w_fim ? S_WRITE : w_tmo ? S_EXC : S_WAIT;
      S_WRITE: w_nxt = S_DONE;
      default: w_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_op         <= 1'b0;
      r_cnt        <= '0;
      o_mult_start <= 1'b0;
      o_div_start  <= 1'b0;
      o_hi_sel     <= 1'b0;
      o_lo_sel     <= 1'b0;
      o_hi_write   <= 1'b0;
      o_lo_write   <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_exc        <= 1'b0;
      o_exc_code   <= 2'b00;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_IDLE && i_req) begin
        r_op       <= i_op_div;
        o_exc_code <= 2'b00;
      end
      if (r_state == S_WAIT && w_nxt == S_EXC)
        o_exc_code <= w_dbz ? 2'b01 : 2'b10;
      r_cnt <= (r_state == S_START) ? '0 :
               (r_state == S_WAIT && r_cnt != CNT_W'(TIMEOUT)) ? r_cnt + 1'b1 : r_cnt;
      o_mult_start <= w_nxt == S_START && !w_op;
      o_div_start  <= w_nxt == S_START && w_op;
      o_hi_sel     <= w_nxt != S_IDLE && w_op;
      o_lo_sel     <= w_nxt != S_IDLE && w_op;
      o_hi_write   <= w_nxt == S_WRITE;
      o_lo_write   <= w_nxt == S_WRITE;
      o_busy       <= w_nxt != S_IDLE;
      o_done       <= w_nxt == S_DONE;
      o_exc        <= w_nxt == S_EXC;
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed scenario tasks for muldiv_sequencer, sampled on the falling edge.
module tb_muldiv_sequencer;
  logic       clk, rst_n, req, op_div, abort, mult_fim, div_fim, div_by_zero;
  logic       mult_start, div_start, hi_sel, lo_sel, hi_write, lo_write, busy, done, exc;
  logic [1:0] exc_code;
  int         checks = 0;
  int         errors = 0;

  muldiv_sequencer #(.TIMEOUT(40), .CNT_W(6)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_op_div(op_div), .i_abort(abort),
    .i_mult_fim(mult_fim), .i_div_fim(div_fim), .i_div_by_zero(div_by_zero),
    .o_mult_start(mult_start), .o_div_start(div_start), .o_hi_sel(hi_sel), .o_lo_sel(lo_sel),
    .o_hi_write(hi_write), .o_lo_write(lo_write), .o_busy(busy), .o_done(done), .o_exc(exc),
    .o_exc_code(exc_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // all outputs as one vector: {mult_start,div_start,hi_sel,lo_sel,hi_write,lo_write,busy,done,exc,exc_code}
  function automatic logic [10:0] outs();
    return {mult_start, div_start, hi_sel, lo_sel, hi_write, lo_write, busy, done, exc, exc_code};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; req = 1'b0; op_div = 1'b0; abort = 1'b0;
    mult_fim = 1'b0; div_fim = 1'b0; div_by_zero = 1'b0;
    #12;
    checks++; if (outs() !== 11'b0) begin errors++; $display("FAIL reset_outs got %b exp %b", outs(), 11'b0); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (outs() !== 11'b0) begin errors++; $display("FAIL idle_outs got %b exp %b", outs(), 11'b0); end
  endtask

  task automatic test_mult;
    logic bad = 1'b0;
    req = 1'b1; op_div = 1'b0;
    @(negedge clk); req = 1'b0;
    checks++; if ({mult_start, div_start, busy, hi_sel} !== 4'b1010) begin errors++; $display("FAIL mult_start got %b exp 1010", {mult_start, div_start, busy, hi_sel}); end
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      bad = bad | mult_start | div_start | hi_write | lo_write | done | exc | ~busy;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL mult_wait got %b exp 0", bad); end
    mult_fim = 1'b1;
    @(negedge clk); mult_fim = 1'b0;
    checks++; if ({hi_write, lo_write, hi_sel, lo_sel, done} !== 5'b11000) begin errors++; $display("FAIL mult_write got %b exp 11000", {hi_write, lo_write, hi_sel, lo_sel, done}); end
    @(negedge clk);
    checks++; if ({done, busy, exc, hi_write} !== 4'b1100) begin errors++; $display("FAIL mult_done got %b exp 1100", {done, busy, exc, hi_write}); end
    @(negedge clk);
    checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL mult_idle got %b exp 00", {done, busy}); end
  endtask

  task automatic test_div;
    logic bad = 1'b0;
    req = 1'b1; op_div = 1'b1;
    @(negedge clk); req = 1'b0; op_div = 1'b0;
    checks++; if ({mult_start, div_start, busy, hi_sel, lo_sel} !== 5'b01111) begin errors++; $display("FAIL div_start got %b exp 01111", {mult_start, div_start, busy, hi_sel, lo_sel}); end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      bad = bad | div_start | hi_write | done | exc | ~hi_sel;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL div_wait got %b exp 0", bad); end
    div_fim = 1'b1;
    @(negedge clk); div_fim = 1'b0;
    checks++; if ({hi_write, lo_write, hi_sel, lo_sel} !== 4'b1111) begin errors++; $display("FAIL div_write got %b exp 1111", {hi_write, lo_write, hi_sel, lo_sel}); end
    @(negedge clk);
    checks++; if ({done, exc, exc_code} !== 4'b1000) begin errors++; $display("FAIL div_done got %b exp 1000", {done, exc, exc_code}); end
  endtask

  task automatic test_div_by_zero;
    @(negedge clk); req = 1'b1; op_div = 1'b1;
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    @(negedge clk); div_by_zero = 1'b1;
    @(negedge clk); div_by_zero = 1'b0;
    checks++; if ({exc, done, hi_write, lo_write, exc_code} !== 6'b100001) begin errors++; $display("FAIL dbz_exc got %b exp 100001", {exc, done, hi_write, lo_write, exc_code}); end
    @(negedge clk);
    checks++; if ({busy, exc, exc_code} !== 4'b0001) begin errors++; $display("FAIL dbz_idle got %b exp 0001", {busy, exc, exc_code}); end
  endtask

  task automatic test_timeout;
    logic bad = 1'b0;
    @(negedge clk); req = 1'b1; op_div = 1'b0;
    @(negedge clk); req = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bad = bad | exc | hi_write | done | ~busy;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL tmo_wait got %b exp 0", bad); end
    @(negedge clk);
    checks++; if ({exc, hi_write, lo_write, done, exc_code} !== 6'b100010) begin errors++; $display("FAIL tmo_exc got %b exp 100010", {exc, hi_write, lo_write, done, exc_code}); end
    @(negedge clk);
    checks++; if ({busy, exc, exc_code} !== 4'b0010) begin errors++; $display("FAIL tmo_idle got %b exp 0010", {busy, exc, exc_code}); end
  endtask

  task automatic test_abort;
    logic bad = 1'b0;
    @(negedge clk); req = 1'b1; op_div = 1'b0;
    @(negedge clk); req = 1'b0;
    checks++; if ({mult_start, exc_code} !== 3'b100) begin errors++; $display("FAIL abort_launch got %b exp 100", {mult_start, exc_code}); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bad = bad | mult_start | div_start | hi_write | done | exc | ~busy;
      div_fim = (k == 2);
      req = (k == 3);
      abort = (k == 5);
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL abort_stray got %b exp 0", bad); end
    @(negedge clk); abort = 1'b0;
    checks++; if (outs() !== 11'b0) begin errors++; $display("FAIL abort_idle got %b exp %b", outs(), 11'b0); end
    @(negedge clk);
    checks++; if ({busy, mult_start, div_start} !== 3'b000) begin errors++; $display("FAIL abort_no_relaunch got %b exp 000", {busy, mult_start, div_start}); end
  endtask

  task automatic test_back_to_back;
    req = 1'b1; op_div = 1'b0;
    @(negedge clk);
    @(negedge clk); mult_fim = 1'b1;
    @(negedge clk); mult_fim = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b exp 1", done); end
    @(negedge clk);
    checks++; if ({busy, mult_start} !== 2'b00) begin errors++; $display("FAIL b2b_idle got %b exp 00", {busy, mult_start}); end
    @(negedge clk); req = 1'b0; abort = 1'b1;
    checks++; if ({busy, mult_start} !== 2'b11) begin errors++; $display("FAIL b2b_relaunch got %b exp 11", {busy, mult_start}); end
    @(negedge clk); abort = 1'b0;
    checks++; if (outs() !== 11'b0) begin errors++; $display("FAIL start_abort got %b exp %b", outs(), 11'b0); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk); req = 1'b1; op_div = 1'b1;
    @(negedge clk); req = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (outs() !== 11'b0) begin errors++; $display("FAIL async_reset got %b exp %b", outs(), 11'b0); end
    @(negedge clk); rst_n = 1'b1; op_div = 1'b0;
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    checks++; if ({mult_start, div_start, busy} !== 3'b101) begin errors++; $display("FAIL post_reset_start got %b exp 101", {mult_start, div_start, busy}); end
    @(negedge clk); mult_fim = 1'b1;
    @(negedge clk); mult_fim = 1'b0;
    checks++; if ({hi_write, done} !== 2'b10) begin errors++; $display("FAIL post_reset_write got %b exp 10", {hi_write, done}); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL post_reset_latency got %b exp 1", done); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_by_zero;
    test_timeout;
    test_abort;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences the shared multiplier and divisor units on behalf of the main control FSM.
- One request launches MULT or DIV. The block then:
  - issues the one-cycle start pulse to the selected unit;
  - waits for its done signal;
  - drives the HI/LO source selects and register write enables.
- Reports completion, divide-by-zero or timeout back to control, which stalls while busy is high.

Parameters:
- TIMEOUT, 40, max cycles spent in WAIT before declaring a timeout exception.
- CNT_W, 6, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  start request from control; sampled in IDLE only.
- op_div  input  1  operation: 0 = MULT, 1 = DIV; latched with req.
- abort  input  1  cancel the current operation; no HI/LO write.
- mult_fim  input  1  multiplier done.
- div_fim  input  1  divisor done.
- div_by_zero  input  1  divisor divide-by-zero flag.
- mult_start  output  1  one-cycle start pulse to the multiplier.
- div_start  output  1  one-cycle start pulse to the divisor.
- hi_sel  output  1  HI mux select: 0 = multiplier, 1 = divisor.
- lo_sel  output  1  LO mux select: 0 = multiplier, 1 = divisor.
- hi_write  output  1  HI register write enable.
- lo_write  output  1  LO register write enable.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle successful-completion pulse.
- exc  output  1  one-cycle exception pulse.
- exc_code  output  2  00 none, 01 divide-by-zero, 10 timeout; holds value until the next accepted req.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE;
  - all outputs 0, exc_code = 00;
  - counter = 0, latched op = 0.
- States: IDLE, START, WAIT, WRITE, DONE, EXC. Registered state; outputs decoded from state and latched op (Moore).
- IDLE:
  - busy = 0.
  - req = 1: latch op_div, clear exc_code to 00, go to START.
  - req = 0: stay in IDLE.
- START (exactly 1 cycle):
  - mult_start = ~op or div_start = op; never both.
  - Clear counter; go to WAIT.
- WAIT:
  - Counter increments each cycle, saturating at TIMEOUT.
  - Priority, highest first:
    1. abort;
    2. op = DIV and div_by_zero = 1: go to EXC, exc_code = 01. Checked every WAIT cycle, not only at div_fim.
    3. done of the selected unit = 1: go to WRITE.
    4. counter = TIMEOUT-1: go to EXC, exc_code = 10.
    5. Otherwise stay in WAIT.
  - The non-selected unit's done signal is ignored.
- WRITE (1 cycle):
  - hi_write = lo_write = 1.
  - hi_sel = lo_sel = latched op; the selects hold this value in every non-IDLE state so the muxes are stable before the write.
  - Go to DONE.
- DONE (1 cycle): done = 1; go to IDLE.
- EXC (1 cycle): exc = 1, no HI/LO write; go to IDLE.
- Abort:
  - Honoured in START and WAIT; next state is IDLE.
  - No done, exc, hi_write or lo_write is produced.
  - exc_code is unchanged.
  - In WRITE, DONE or EXC, abort is ignored; these states complete normally.
- req:
  - Ignored while busy; never queued.
  - req held high continuously re-launches one cycle after returning to IDLE.
- Minimum latency, req to done: req accepted cycle N; START N+1; WAIT N+2 with fim seen; WRITE N+3; done high N+4.
- done and exc are never high in the same cycle.
- mult_start and div_start are never high in the same cycle.
- Reset asserted mid-operation aborts immediately; no write occurs.

Test Plan:
- MULT basic: req=1, op_div=0; mult_fim pulses 33 cycles after mult_start -> mult_start high 1 cycle; hi_write = lo_write = 1 with hi_sel = lo_sel = 0 one cycle after mult_fim; done 1 cycle later; busy drops.
- DIV basic: req, op_div=1, div_fim after 32 cycles, div_by_zero=0 -> div_start only; write with sels = 1; done; exc_code = 00.
- Divide-by-zero: DIV with div_by_zero=1 on the 2nd WAIT cycle -> exc pulse next cycle, exc_code = 01, no hi_write or lo_write, busy = 0 after.
- Timeout: TIMEOUT=40, MULT with mult_fim never asserted -> exc after 40 WAIT cycles, exc_code = 10, no write.
- Abort and ignored inputs:
  - abort asserted in WAIT cycle 5 -> IDLE next cycle, no done, exc or write;
  - a stray div_fim during a MULT is ignored;
  - req pulses while busy produce no extra start.
- Reset mid-WAIT: reset=0 asynchronously -> all outputs 0 immediately; after release, a new req=1 launches normally with 4-cycle minimum latency.
